exp_seq_ctrl: RTL

Sequencer that sits directly upstream of the exponential unit and feeds it. It accepts a stream of IEEE-754 double operands over a valid/ready handshake and buffers them in a small FIFO. It issues one operand at a time to the exponential unit, holding num_64/enable stable for the unit's fixed 28-cycle window, then returns each result downstream tagged with its element index and vector-last flag.

---
 rtl/exp_seq_pkg.sv | 21 ++
 rtl/exp_seq_ctrl_if.sv | 40 ++++
 rtl/exp_seq_fifo.sv | 55 +++++
 rtl/exp_seq_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/exp_seq_pkg.sv
// Shared definitions for the exponential-unit sequencer: FSM state
// encoding, default latency/timeout constants and IEEE-754 double field widths.
package exp_seq_pkg;

  localparam int DBL_SIGN_W = 1;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_MAN_W  = 52;
  localparam int DBL_W      = DBL_SIGN_W + DBL_EXP_W + DBL_MAN_W;

  // Fixed exp unit window and the optional WAIT watchdog limit
  localparam int EXP_LAT_DEF = 28;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } exp_seq_state_e;

endpackage

// File: rtl/exp_seq_ctrl_if.sv
// Bundle of the three streams around the sequencer: operand input,
// exp unit request/response, and the tagged result output.
//
// Handshake: a transfer on a valid/ready pair happens on a rising clock edge
// where both valid and ready are 1. Once valid is raised, the source holds
// valid and its payload stable until that transfer; ready may change freely
// and never depends combinationally on valid. exp_valid is a one-cycle pulse
// with no ready.
interface exp_seq_ctrl_if #(parameter int IDX_W = 8);
  import exp_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DBL_W-1:0]  in_data;
  logic              in_last;

  logic [DBL_W-1:0]  exp_num_64;
  logic              exp_enable;
  logic              exp_valid;
  logic [DBL_W-1:0]  exp_value;

  logic              out_valid;
  logic              out_ready;
  logic [DBL_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  // Sequencer side
  modport slave (
    input  in_valid, in_data, in_last, exp_valid, exp_value, out_ready,
    output in_ready, exp_num_64, exp_enable, out_valid, out_data, out_idx, out_last
  );

  // Environment side: operand source, exp unit and result sink
  modport master (
    output in_valid, in_data, in_last, exp_valid, exp_value, out_ready,
    input  in_ready, exp_num_64, exp_enable, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/exp_seq_fifo.sv
// Small operand FIFO (DEPTH entries of W bits). Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module exp_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; wraps naturally mod DEPTH through the low bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset discards all buffered entries
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are meaningless until the pointers cover them
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/exp_seq_ctrl.sv
// Sequencer feeding the exponential unit: buffers double operands, issues
// one at a time with exp_num_64/exp_enable held for the unit's window, and
// returns each result tagged with its element index and last flag.
// Optional feature: define EXP_SEQ_TIMEOUT_EN to add a WAIT watchdog and the
// sticky err_timeout output.
module exp_seq_ctrl
  import exp_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 8,
  parameter int EXP_LAT = EXP_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           srstn,
  exp_seq_ctrl_if.slave  bus,
  output logic           busy,
`ifdef EXP_SEQ_TIMEOUT_EN
  output logic           err_timeout,
`endif
  output exp_seq_state_e state_dbg
);

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("exp_seq_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT <= EXP_LAT) begin : g_bad_timeout
    $error("exp_seq_ctrl: TIMEOUT must exceed EXP_LAT");
  end

  exp_seq_state_e    state_q;
  logic [DBL_W-1:0]  exp_num_q;
  logic              exp_enable_q;
  logic              last_q;
  logic [IDX_W-1:0]  idx_q;
  logic              out_valid_q;
  logic [DBL_W-1:0]  out_data_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              out_last_q;

  logic              fifo_full, fifo_empty;
  logic [DBL_W:0]    fifo_rdata;
  logic              issue;

`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt_q;
  logic          err_q;
  assign err_timeout = err_q;
`endif

  // Issue only when an operand is waiting and the result slot is free or
  // being freed this very cycle, so a capture never overwrites a result.
  assign issue = (state_q == S_IDLE) && !fifo_empty &&
                 (!out_valid_q || bus.out_ready);

  exp_seq_fifo #(.DEPTH(DEPTH), .W(DBL_W + 1)) u_fifo (
    .clk   (clk),
    .srstn (srstn),
    .push  (bus.in_valid),
    .wdata ({bus.in_last, bus.in_data}),
    .pop   (issue),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.in_ready   = !fifo_full;
  assign bus.exp_num_64 = exp_num_q;
  assign bus.exp_enable = exp_enable_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_last   = out_last_q;
  assign busy           = !fifo_empty || (state_q != S_IDLE);
  assign state_dbg      = state_q;

  // Sequencer FSM with all exp-unit and result outputs registered.
  // Enable rises on the edge that enters ISSUE and stays high through the
  // capture cycle; GAP plus IDLE give the unit two low cycles to clear.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= S_IDLE;
      exp_num_q    <= '0;
      exp_enable_q <= 1'b0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
`ifdef EXP_SEQ_TIMEOUT_EN
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            exp_num_q    <= fifo_rdata[DBL_W-1:0];
            last_q       <= fifo_rdata[DBL_W];
            exp_enable_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          exp_enable_q <= 1'b1;
`ifdef EXP_SEQ_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.exp_valid) begin
            out_data_q   <= bus.exp_value;
            out_idx_q    <= idx_q;
            out_last_q   <= last_q;
            out_valid_q  <= 1'b1;
            idx_q        <= last_q ? '0 : idx_q + 1'b1;
            exp_enable_q <= 1'b0;
            state_q      <= S_GAP;
          end
`ifdef EXP_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LAST) begin
            err_q        <= 1'b1;
            exp_enable_q <= 1'b0;
            state_q      <= S_GAP;
          end else begin
            wait_cnt_q   <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          exp_enable_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
